quad_decoder: RTL and testbench

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder.sv | 172 +++++++++++++++++
 tb/tb_quad_decoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature encoder front end producing one-cycle count strobes
// (enable with up/down) for a downstream up/down counter, plus a sticky error
// flag for illegal two-bit phase jumps.
// Both phase channels pass through a SYNC_STAGES-deep synchronizer. When the
// macro QUAD_FILTER_EN is defined, a FILTER_LEN-cycle stability filter sits
// between the synchronizer and the FSM. Without the macro the synchronized
// value drives the FSM directly and FILTER_LEN has no effect on behaviour.
module quad_decoder #(
  parameter int SYNC_STAGES = 2,   // legal range 2..4
  parameter int FILTER_LEN  = 3    // legal range 1..15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable_in,
  input  logic phase_a,
  input  logic phase_b,
  input  logic clear_err,
  output logic enable,
  output logic up,
  output logic down,
  output logic dir,
  output logic error_flag
);

  // State encoding: bit 2 marks INIT, bits 1:0 hold the accepted AB value.
  localparam logic [2:0] ST_INIT = 3'b100;
  localparam logic [2:0] ST_S00  = 3'b000;
  localparam logic [2:0] ST_S01  = 3'b001;
  localparam logic [2:0] ST_S11  = 3'b011;
  localparam logic [2:0] ST_S10  = 3'b010;

`ifdef QUAD_FILTER_EN
  localparam int INIT_LEN = SYNC_STAGES + FILTER_LEN;
`else
  localparam int INIT_LEN = SYNC_STAGES;
`endif
  // The INIT counter is sized for the filtered build so one width fits both.
  localparam int                INIT_W    = $clog2(SYNC_STAGES + FILTER_LEN + 2);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_LEN);

  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [1:0]             sync_ab;
  logic [1:0]             filt_ab;
  logic [2:0]             state;
  logic [INIT_W-1:0]      init_cnt;
  logic [1:0]             step_delta;

  // Position of an AB value along the forward (up) sequence 00,10,11,01.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    logic [1:0] pos;
    pos = 2'd0;
    case (ab)
      2'b00:   pos = 2'd0;
      2'b10:   pos = 2'd1;
      2'b11:   pos = 2'd2;
      default: pos = 2'd3;
    endcase
    return pos;
  endfunction

  // Synchronizer chains bringing the asynchronous channels into the clock domain.
  // NOTE: sequential state is written with non-blocking assignments only, and
  // the reset branch is evaluated inside the clocked block (synchronous reset).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], phase_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], phase_b};
    end
  end

  assign sync_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

`ifdef QUAD_FILTER_EN
  localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

  logic [1:0] cand_ab;
  logic [3:0] filt_cnt;

  // Accept a new AB value only after it has been seen unchanged for FILTER_LEN edges.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      filt_ab  <= 2'b00;
      cand_ab  <= 2'b00;
      filt_cnt <= 4'd0;
    end else if (sync_ab == filt_ab) begin
      filt_cnt <= 4'd0;
    end else if (filt_cnt != 4'd0 && sync_ab == cand_ab) begin
      if (filt_cnt == FILT_LAST) begin
        filt_ab  <= cand_ab;
        filt_cnt <= 4'd0;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end else begin
      // First edge of a new candidate (or the candidate changed): restart.
      cand_ab <= sync_ab;
      if (FILTER_LEN == 1) begin
        filt_ab  <= sync_ab;
        filt_cnt <= 4'd0;
      end else begin
        filt_cnt <= 4'd1;
      end
    end
  end
`else
  assign filt_ab = sync_ab;
`endif

  assign step_delta = gray_pos(filt_ab) - gray_pos(state[1:0]);

  // Decoder FSM: tracks the accepted AB value, issues strobes and flags illegal jumps.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      enable     <= 1'b0;
      up         <= 1'b0;
      down       <= 1'b0;
      dir        <= 1'b1;
      error_flag <= 1'b0;
    end else begin
      // NOTE: strobe outputs default low every cycle so each pulse lasts one
      // cycle; clear_err is applied before the illegal-step set so the set wins.
      enable <= 1'b0;
      up     <= 1'b0;
      down   <= 1'b0;
      if (clear_err) begin
        error_flag <= 1'b0;
      end
      if (state == ST_INIT) begin
        if (init_cnt == INIT_LAST) begin
          state <= {1'b0, filt_ab};
        end else begin
          init_cnt <= init_cnt + 1'b1;
        end
      end else if (filt_ab != state[1:0]) begin
        state <= {1'b0, filt_ab};
        case (step_delta)
          2'd1: begin
            dir <= 1'b1;
            if (enable_in) begin
              enable <= 1'b1;
              up     <= 1'b1;
            end
          end
          2'd3: begin
            dir <= 1'b0;
            if (enable_in) begin
              enable <= 1'b1;
              down   <= 1'b1;
            end
          end
          2'd2: begin
            error_flag <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // State constants for the accepted-value states, kept for readability of
  // waveform/debug views; the FSM stores them as {1'b0, AB}.
  logic unused_states;
  assign unused_states = ^{ST_S00, ST_S01, ST_S11, ST_S10};

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed-vector bench for quad_decoder with default
// parameters. Works for both builds; filter-specific cases depend on QUAD_FILTER_EN.
module tb_quad_decoder;

`ifdef QUAD_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif
  localparam int HOLD = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic enable_in = 1'b1;
  logic phase_a = 1'b1;
  logic phase_b = 1'b1;
  logic clear_err = 1'b0;
  logic enable, up, down, dir, error_flag;

  int n_cmp = 0;
  int n_bad = 0;
  int viol  = 0;

  quad_decoder dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable_in  (enable_in),
    .phase_a    (phase_a),
    .phase_b    (phase_b),
    .clear_err  (clear_err),
    .enable     (enable),
    .up         (up),
    .down       (down),
    .dir        (dir),
    .error_flag (error_flag)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock, then settle; also watches the strobe encoding rules.
  task automatic tick();
    @(posedge clock);
    #1;
    if ((up && down) || (enable && !up && !down)) viol++;
  endtask

  // Drive a new AB value, hold it HOLD cycles, check strobe count/latency/direction.
  task automatic run_step(input string tag, input logic [1:0] ab, input int exp_n,
                          input logic exp_up);
    int n = 0;
    int at = 0;
    logic up_at = 1'b0;
    logic dn_at = 1'b0;
    {phase_a, phase_b} = ab;
    for (int k = 1; k <= HOLD; k++) begin
      tick();
      if (enable) begin
        n++;
        at = k;
        up_at = up;
        dn_at = down;
      end
    end
    check({tag, "_cnt"}, n, exp_n);
    if (exp_n == 1) begin
      check({tag, "_lat"}, at, LAT);
      check({tag, "_up"}, {31'd0, up_at}, {31'd0, exp_up});
      check({tag, "_dn"}, {31'd0, dn_at}, {31'd0, !exp_up});
    end
  endtask

  initial begin
    int n;
    int en_seen;
    int err_seen;
    int at1, at2;
    logic up1, dn2;

    // Reset with AB=11 held.
    repeat (3) tick();
    check("rst_enable", {31'd0, enable}, 0);
    check("rst_up", {31'd0, up}, 0);
    check("rst_down", {31'd0, down}, 0);
    check("rst_dir", {31'd0, dir}, 1);
    check("rst_err", {31'd0, error_flag}, 0);
    check("rst_state", {29'd0, dut.state}, 3'b100);

    reset_n = 1'b1;
    en_seen = 0;
    err_seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (enable) en_seen++;
      if (error_flag) err_seen++;
    end
    check("init_no_strobe", en_seen, 0);
    check("init_no_err", err_seen, 0);
    check("init_state_s11", {29'd0, dut.state}, 3'b011);

    // Walk 11 -> 01 -> 00 (both up steps).
    run_step("s11_01", 2'b01, 1, 1'b1);
    run_step("s01_00", 2'b00, 1, 1'b1);

    // Four forward steps.
    run_step("fwd_10", 2'b10, 1, 1'b1);
    run_step("fwd_11", 2'b11, 1, 1'b1);
    run_step("fwd_01", 2'b01, 1, 1'b1);
    run_step("fwd_00", 2'b00, 1, 1'b1);
    check("fwd_dir", {31'd0, dir}, 1);

    // Four reverse steps.
    run_step("rev_01", 2'b01, 1, 1'b0);
    run_step("rev_11", 2'b11, 1, 1'b0);
    run_step("rev_10", 2'b10, 1, 1'b0);
    run_step("rev_00", 2'b00, 1, 1'b0);
    check("rev_dir", {31'd0, dir}, 0);

    // Forward steps with strobes gated off; FSM must still track.
    enable_in = 1'b0;
    run_step("gated_10", 2'b10, 0, 1'b1);
    check("gated_state_10", {29'd0, dut.state}, 3'b010);
    run_step("gated_11", 2'b11, 0, 1'b1);
    run_step("gated_01", 2'b01, 0, 1'b1);
    run_step("gated_00", 2'b00, 0, 1'b1);
    check("gated_state_00", {29'd0, dut.state}, 3'b000);
    enable_in = 1'b1;
    n = 0;
    for (int k = 0; k < HOLD; k++) begin
      tick();
      if (enable) n++;
    end
    check("reenable_no_stale", n, 0);
    check("gated_no_err", {31'd0, error_flag}, 0);

`ifdef QUAD_FILTER_EN
    // Two-cycle glitch on phase_a must be rejected.
    phase_a = 1'b1;
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2) phase_a = 1'b0;
      if (enable) n++;
    end
    check("glitch2_no_strobe", n, 0);
    check("glitch2_no_err", {31'd0, error_flag}, 0);
    check("glitch2_state", {29'd0, dut.state}, 3'b000);

    // Three-cycle pulse passes: up strobe at LAT, down strobe three cycles later.
    phase_a = 1'b1;
    n = 0;
    at1 = 0;
    at2 = 0;
    up1 = 1'b0;
    dn2 = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 3) phase_a = 1'b0;
      if (enable) begin
        n++;
        if (n == 1) begin
          at1 = k;
          up1 = up;
        end else begin
          at2 = k;
          dn2 = down;
        end
      end
    end
    check("pulse3_cnt", n, 2);
    check("pulse3_up_at", at1, 6);
    check("pulse3_up", {31'd0, up1}, 1);
    check("pulse3_dn_at", at2, 9);
    check("pulse3_dn", {31'd0, dn2}, 1);
`endif

    // Illegal jump 00 -> 11.
    run_step("ill_00_11", 2'b11, 0, 1'b1);
    check("ill_err_set", {31'd0, error_flag}, 1);
    check("ill_state_11", {29'd0, dut.state}, 3'b011);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("clr_err", {31'd0, error_flag}, 0);

    // Legal 11 -> 01, then illegal 01 -> 10 with clear_err on the detecting edge.
    run_step("s11_01_b", 2'b01, 1, 1'b1);
    {phase_a, phase_b} = 2'b10;
    n = 0;
    for (int k = 1; k <= HOLD; k++) begin
      if (k == LAT) clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      if (enable) n++;
      if (k == LAT - 1) check("coinc_err_before", {31'd0, error_flag}, 0);
      if (k == LAT) check("coinc_err_kept", {31'd0, error_flag}, 1);
    end
    check("coinc_no_strobe", n, 0);

    // Down step 10 -> 00 so dir=0 and error still set before reset.
    run_step("s10_00", 2'b00, 1, 1'b0);
    check("pre_rst_dir", {31'd0, dir}, 0);
    check("pre_rst_err", {31'd0, error_flag}, 1);

    // Reset for one cycle two cycles after a step.
    {phase_a, phase_b} = 2'b10;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_enable", {31'd0, enable}, 0);
    check("mid_rst_up", {31'd0, up}, 0);
    check("mid_rst_down", {31'd0, down}, 0);
    check("mid_rst_dir", {31'd0, dir}, 1);
    check("mid_rst_err", {31'd0, error_flag}, 0);
    check("mid_rst_state", {29'd0, dut.state}, 3'b100);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (enable) n++;
    end
    check("mid_rst_no_strobe", n, 0);
    check("mid_rst_reload", {29'd0, dut.state}, 3'b010);

    check("strobe_encoding", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
